// File: rtl/fifo_drain_ctrl_if.sv
// Read port of the dual-clock FIFO as seen from the read clock domain.
// master = drain controller (pops), slave = FIFO (presents head word and empty flag).
interface fifo_drain_ctrl_if #(
  parameter int DSIZE = 8
);
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;

  modport master (
    input  rempty,
    input  rdata,
    output rinc
  );

  modport slave (
    output rempty,
    output rdata,
    input  rinc
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Drains up to DEPTH words from a FWFT FIFO into a local capture memory.
// Pops combinationally while DRAIN and FIFO non-empty; stalls abort after TIMEOUT empty cycles.
module fifo_drain_ctrl #(
  parameter int DSIZE   = 8,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW:0]      count,
  fifo_drain_ctrl_if.master fifo,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [AW:0]      words_rcvd,
  input  logic [AW-1:0]    rd_addr,
  output logic [DSIZE-1:0] rd_data
);

  localparam int          DEPTH      = 1 << AW;
  localparam int          SW         = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] DEPTH_W    = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE,
    ERR
  } state_t;

  state_t           state, state_nxt;
  logic [AW:0]      target, target_nxt;
  logic [AW:0]      words_nxt;
  logic [SW-1:0]    stall_cnt, stall_nxt;
  logic             timeout_nxt;
  logic             pop;
  logic             last_pop;
  logic [DSIZE-1:0] mem [DEPTH];

  // Pop is gated by state so an underflow or out-of-drain pop cannot occur.
  assign pop       = (state == DRAIN) && !fifo.rempty;
  assign last_pop  = pop && (words_rcvd == (target - (AW + 1)'(1)));
  assign fifo.rinc = pop;
  assign busy      = (state == DRAIN);
  assign done      = (state == DONE);

  always_comb begin
    state_nxt   = state;
    target_nxt  = target;
    words_nxt   = words_rcvd;
    stall_nxt   = stall_cnt;
    timeout_nxt = timeout;
    case (state)
      IDLE: begin
        if (start) begin
          target_nxt  = (count > DEPTH_W) ? DEPTH_W : count;
          words_nxt   = '0;
          stall_nxt   = '0;
          timeout_nxt = 1'b0;
          state_nxt   = (count == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (pop) begin
          words_nxt = words_rcvd + (AW + 1)'(1);
          stall_nxt = '0;
          if (last_pop) begin
            state_nxt = DONE;
          end
        end else begin
          stall_nxt = stall_cnt + SW'(1);
          if (stall_cnt == STALL_LAST) begin
            state_nxt = ERR;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      ERR: begin
        timeout_nxt = 1'b1;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      target     <= '0;
      words_rcvd <= '0;
      stall_cnt  <= '0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      target     <= target_nxt;
      words_rcvd <= words_nxt;
      stall_cnt  <= stall_nxt;
      timeout    <= timeout_nxt;
    end
  end

  // Capture memory is deliberately unreset; contents persist until overwritten.
  always_ff @(posedge clk) begin
    if (pop) begin
      mem[words_rcvd[AW-1:0]] <= fifo.rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed table-driven bench for fifo_drain_ctrl with a behavioural FWFT FIFO model.
module tb_fifo_drain_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] count = '0;
  logic       busy, done, timeout;
  logic [4:0] words_rcvd;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;

  fifo_drain_ctrl_if #(.DSIZE(8)) dif ();

  fifo_drain_ctrl #(.DSIZE(8), .AW(4), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .count      (count),
    .fifo       (dif),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .words_rcvd (words_rcvd),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] dtab [16] = '{8'd4, 8'd14, 8'd24, 8'd42, 8'd141, 8'd243, 8'd41, 8'd134,
                            8'd204, 8'd124, 8'd104, 8'd24, 8'd34, 8'd74, 8'd84, 8'd95};

  function automatic logic [7:0] w(input int i, input int seed);
    return dtab[(i + seed) % 16];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // FIFO model: head word valid whenever non-empty; pop applied on the edge ending a rinc cycle.
  logic [7:0] q[$];
  logic [7:0] src[$];
  bit         slow_mode = 1'b0;
  bit         pend;
  int         fcyc = 0;

  initial begin
    dif.rempty = 1'b1;
    dif.rdata  = '0;
    forever begin
      @(negedge clk);
      pend = dif.rinc;
      @(posedge clk);
      #1;
      if (pend && q.size() > 0) void'(q.pop_front());
      fcyc++;
      if (slow_mode && src.size() > 0 && (fcyc % 4) == 0) q.push_back(src.pop_front());
      dif.rempty = (q.size() == 0);
      dif.rdata  = (q.size() > 0) ? q[0] : 8'd0;
    end
  end

  typedef struct {
    int cnt;
    int nload;
    int seed;
    bit slow;
    int pulse;
    int e_pops;
    int e_words;
    int e_done;
    int e_dlat;
    int e_to;
    int e_tlat;
  } vec_t;

  vec_t vt[7];

  task automatic rd_chk(input int addr, input int exp);
    @(negedge clk);
    rd_addr = 4'(addr);
    @(negedge clk);
    chk($sformatf("rd_data[%0d]", addr), int'(rd_data), exp);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int pops = 0, done_n = 0, done_c = -1, to_c = -1, viol = 0, c, tail = -1;
    bit fin = 1'b0;
    @(negedge clk);
    q.delete();
    src.delete();
    slow_mode = v.slow;
    for (int i = 0; i < v.nload; i++) begin
      if (v.slow) src.push_back(w(i, v.seed));
      else        q.push_back(w(i, v.seed));
    end
    start = 1'b1;
    count = 5'(v.cnt);
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (c <= 300) begin
      if (dif.rinc) pops++;
      if (dif.rinc && dif.rempty) viol++;
      if (done) begin
        done_n++;
        if (done_c < 0) done_c = c;
      end
      if (timeout && to_c < 0) to_c = c;
      if (v.pulse == c) begin
        start = 1'b1;
        count = 5'd16;
      end else begin
        start = 1'b0;
      end
      if (tail < 0 && (done_n > 0 || to_c >= 0)) tail = 3;
      if (tail == 0) begin
        fin = 1'b1;
        break;
      end
      if (tail > 0) tail--;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    slow_mode = 1'b0;
    chk($sformatf("v%0d finished", id), int'(fin), 1);
    chk($sformatf("v%0d pops", id), pops, v.e_pops);
    chk($sformatf("v%0d rinc_while_empty", id), viol, 0);
    chk($sformatf("v%0d words_rcvd", id), int'(words_rcvd), v.e_words);
    chk($sformatf("v%0d done_pulses", id), done_n, v.e_done);
    chk($sformatf("v%0d timeout", id), int'(timeout), v.e_to);
    chk($sformatf("v%0d busy_end", id), int'(busy), 0);
    if (v.e_dlat >= 0) chk($sformatf("v%0d done_latency", id), done_c, v.e_dlat);
    if (v.e_tlat >= 0) chk($sformatf("v%0d timeout_latency", id), to_c, v.e_tlat);
    for (int i = 0; i < v.e_words; i++) rd_chk(i, int'(w(i, v.seed)));
  endtask

  initial begin
    int n;
    int pops;
    vec_t rv;

    //        cnt nload seed slow pulse pops words done dlat to tlat
    vt[0] = '{16, 16,   0,   0,   0,    16,  16,   1,   17,  0, -1};
    vt[1] = '{16, 16,   3,   1,   0,    16,  16,   1,   -1,  0, -1};
    vt[2] = '{ 8,  5,   7,   0,   0,     5,   5,   0,   -1,  1, 71};
    vt[3] = '{ 0,  4,   0,   0,   0,     0,   0,   1,    1,  0, -1};
    vt[4] = '{20, 20,   2,   0,   0,    16,  16,   1,   17,  0, -1};
    vt[5] = '{ 6, 10,  11,   0,   3,     6,   6,   1,    7,  0, -1};
    vt[6] = '{ 3,  5,   1,   0,   0,     3,   3,   1,    4,  0, -1};

    q.push_back(8'd55);
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset timeout", int'(timeout), 0);
    chk("reset words_rcvd", int'(words_rcvd), 0);
    chk("reset rd_data", int'(rd_data), 0);
    chk("reset rinc", int'(dif.rinc), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle rinc with data", int'(dif.rinc), 0);

    for (int k = 0; k < 7; k++) run_vec(k, vt[k]);

    // Async reset in the middle of a drain, then a fresh drain from index 0.
    @(negedge clk);
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(w(i, 5));
    start = 1'b1;
    count = 5'd16;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    pops = 0;
    while (pops < 7 && n < 50) begin
      if (dif.rinc) pops++;
      @(negedge clk);
      n++;
    end
    chk("mid words before reset", int'(words_rcvd), 7);
    chk("mid rinc before reset", int'(dif.rinc), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid reset busy", int'(busy), 0);
    chk("mid reset rinc", int'(dif.rinc), 0);
    chk("mid reset words_rcvd", int'(words_rcvd), 0);
    chk("mid reset rd_data", int'(rd_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    rv = '{4, 4, 9, 0, 0, 4, 4, 1, 5, 0, -1};
    run_vec(7, rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
